// File: rtl/mack_bus_controller.sv
// 68000 bus controller: region decode into active-low chip selects, boot ROM overlay,
// per-region DTACK generation (internal wait count or external pass-through) and bus timeout.
module mack_bus_controller #(
  parameter int unsigned AW          = 9,
  parameter int unsigned NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS*AW-1:0] REGION_BASE = {9'h000, 9'h078, 9'h070},
  parameter logic [NUM_REGIONS*AW-1:0] REGION_MASK = {9'h1F0, 9'h1F8, 9'h1F8},
  parameter logic [NUM_REGIONS*4-1:0]  REGION_WAIT = {4'd0, 4'd0, 4'd1},
  parameter logic [NUM_REGIONS-1:0]    REGION_EXT  = 3'b010,
  parameter int unsigned BOOT_CYCLES = 8,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CLKDIV_BITS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AW-1:0]          addr_i,
  input  logic                   as_i,
  input  logic                   iack_i,
  input  logic                   dtack_in_i,
  output logic [NUM_REGIONS-1:0] cs_o,
  output logic                   dtack_o,
  output logic                   berr_o,
  output logic                   boot_o,
  output logic                   clk_slow_o
);

  localparam logic [9:0] TimeoutM1 = 10'(TIMEOUT - 1);
  localparam logic [7:0] BootCyc   = 8'(BOOT_CYCLES);

  typedef enum logic [2:0] {StIdle, StWait, StExt, StAck, StFault} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic [9:0]             tcnt_q, tcnt_d;
  logic                   ext_q, ext_d;
  logic                   as_q, as_qq;
  logic [7:0]             boot_cnt_q;
  logic                   boot_q;
  logic [CLKDIV_BITS-1:0] div_q;

  logic [NUM_REGIONS-1:0] hit, sel;
  logic                   win_valid, win_ext, timeout;
  logic [3:0]             win_wait;
  logic [9:0]             tcnt_inc;

  // Decode; the loop runs high to low so the lowest-index hit is the last writer.
  always_comb begin
    hit       = '0;
    sel       = '0;
    win_valid = 1'b0;
    win_wait  = '0;
    win_ext   = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = ((addr_i ^ REGION_BASE[i*AW +: AW]) & REGION_MASK[i*AW +: AW]) == '0;
    end
    if (!boot_q) begin
      sel[0]    = 1'b1;
      win_valid = 1'b1;
      win_wait  = REGION_WAIT[3:0];
      win_ext   = REGION_EXT[0];
    end else begin
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
        if (hit[i]) begin
          sel       = '0;
          sel[i]    = 1'b1;
          win_valid = 1'b1;
          win_wait  = REGION_WAIT[i*4 +: 4];
          win_ext   = REGION_EXT[i];
        end
      end
    end
    cs_o = ~(sel & {NUM_REGIONS{~as_i & iack_i & ~rst_i}});
  end

  // AS is registered once; the FSM and the boot counter both work off the sampled copy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      as_q       <= 1'b1;
      as_qq      <= 1'b1;
      boot_cnt_q <= '0;
      boot_q     <= 1'b0;
      div_q      <= '0;
    end else begin
      as_q  <= as_i;
      as_qq <= as_q;
      div_q <= div_q + CLKDIV_BITS'(1);
      if (!as_q && as_qq && boot_cnt_q != 8'hFF) begin
        boot_cnt_q <= boot_cnt_q + 8'd1;
      end
      if (as_q && !as_qq && boot_cnt_q >= BootCyc) begin
        boot_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      ext_q   <= ext_d;
    end
  end

  assign tcnt_inc = (tcnt_q == 10'h3FF) ? tcnt_q : tcnt_q + 10'd1;
  assign timeout  = (tcnt_inc == TimeoutM1);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    ext_d   = ext_q;
    unique case (state_q)
      StIdle: begin
        if (!as_q) begin
          tcnt_d  = '0;
          wcnt_d  = win_wait;
          ext_d   = win_ext;
          state_d = (!iack_i || !win_valid) ? StExt : StWait;
        end
      end
      StWait: begin
        if (as_q) begin
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_inc;
          if (ext_q) begin
            state_d = timeout ? StFault : StExt;
          end else if (wcnt_q == '0) begin
            state_d = StAck;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
            if (timeout) state_d = StFault;
          end
        end
      end
      StExt: begin
        if (as_q) begin
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_inc;
          // Acknowledge takes priority over a timeout landing on the same edge.
          if (!dtack_in_i)  state_d = StAck;
          else if (timeout) state_d = StFault;
        end
      end
      StAck, StFault: begin
        if (as_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign dtack_o    = (state_q != StAck);
  assign berr_o     = (state_q != StFault);
  assign boot_o     = boot_q;
  assign clk_slow_o = div_q[CLKDIV_BITS-1];

endmodule

// File: tb/tb_mack_bus_controller.sv
// Scoreboard bench for mack_bus_controller: each bus cycle queues its expected chip
// selects, response and latency, which are popped and compared when the DUT responds.
module tb_mack_bus_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] addr = '0;
  logic       as_n = 1'b1;
  logic       iack_n = 1'b1;
  logic       dtack_in_n = 1'b1;
  logic [2:0] cs;
  logic       dtack_n, berr_n, boot, clk_slow;

  int n_cmp = 0;
  int n_err = 0;
  int ncyc;

  typedef struct {
    logic [2:0] cs;
    logic [1:0] resp;
    int         lat;
  } exp_t;
  exp_t sb[$];

  localparam logic [1:0] RespAck  = 2'b01;
  localparam logic [1:0] RespBerr = 2'b10;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  mack_bus_controller dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .addr_i     (addr),
    .as_i       (as_n),
    .iack_i     (iack_n),
    .dtack_in_i (dtack_in_n),
    .cs_o       (cs),
    .dtack_o    (dtack_n),
    .berr_o     (berr_n),
    .boot_o     (boot),
    .clk_slow_o (clk_slow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ext_at: negedge index at which DTACK_IN is pulled low (-1 = never).
  task automatic bus_cycle(input string tag, input logic [8:0] a, input logic iack,
                           input int ext_at, input logic [2:0] e_cs, input logic [1:0] e_resp,
                           input int e_lat);
    exp_t       e;
    logic [2:0] cs_seen;
    int         c;
    bit         done;
    sb.push_back('{cs: e_cs, resp: e_resp, lat: e_lat});
    @(negedge clk);
    addr = a; iack_n = iack; dtack_in_n = 1'b1; as_n = 1'b0;
    c = 0; done = 0; cs_seen = 3'b111;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) cs_seen = cs;
      if (!dtack_n || !berr_n) done = 1;
      else if (c == ext_at) dtack_in_n = 1'b0;
    end
    e = sb.pop_front();
    check({tag, "/cs"}, 32'(cs_seen), 32'(e.cs));
    check({tag, "/resp"}, 32'({dtack_n, berr_n}), 32'(e.resp));
    check({tag, "/lat"}, 32'(c - 1), 32'(e.lat));
    as_n = 1'b1; dtack_in_n = 1'b1; iack_n = 1'b1;
    #1 check({tag, "/cs_off"}, 32'(cs), 32'h7);
    repeat (2) @(negedge clk);
    check({tag, "/release"}, 32'({dtack_n, berr_n}), 32'h3);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst/cs", 32'(cs), 32'h7);
    check("rst/dtack_berr", 32'({dtack_n, berr_n}), 32'h3);
    check("rst/boot", 32'(boot), 32'h0);
    check("rst/clk_slow", 32'(clk_slow), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: overlay maps every access to ROM (cs[0], one wait state).
    for (int i = 0; i < 8; i++) begin
      bus_cycle($sformatf("t1_%0d", i), 9'h000, 1'b1, -1, 3'b110, RespAck, 3);
      check($sformatf("t1_boot_%0d", i), 32'(boot), 32'(i == 7));
    end
    bus_cycle("t1_ram", 9'h000, 1'b1, -1, 3'b011, RespAck, 2);

    // T2: ROM after overlay, WAIT=1.
    bus_cycle("t2_rom", 9'h070, 1'b1, -1, 3'b110, RespAck, 3);
    check("clk_slow", 32'(clk_slow), 32'(ncyc & 1));

    // T3: MFP waits on external DTACK.
    bus_cycle("t3_mfp", 9'h078, 1'b1, 5, 3'b101, RespAck, 5);
    bus_cycle("t3_mfp_slow", 9'h07F, 1'b1, 20, 3'b101, RespAck, 20);
    // DTACK_IN and timeout on the same edge: acknowledge wins.
    bus_cycle("t3_race", 9'h078, 1'b1, 64, 3'b101, RespAck, 64);

    // T4: unmapped address times out.
    bus_cycle("t4_unmapped", 9'h040, 1'b1, -1, 3'b111, RespBerr, 64);

    // T5: interrupt acknowledge.
    bus_cycle("t5_iack_ack", 9'h070, 1'b0, 7, 3'b111, RespAck, 7);
    bus_cycle("t5_iack_spur", 9'h070, 1'b0, -1, 3'b111, RespBerr, 64);

    // T6: reset in the middle of a ROM wait state.
    @(negedge clk);
    addr = 9'h070; as_n = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6/cs", 32'(cs), 32'h7);
    check("t6/dtack_berr", 32'({dtack_n, berr_n}), 32'h3);
    check("t6/boot", 32'(boot), 32'h0);
    @(negedge clk);
    as_n = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus_cycle("t6_overlay", 9'h000, 1'b1, -1, 3'b110, RespAck, 3);
    check("t6/boot_after", 32'(boot), 32'h0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
